// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF neuron scheduler: one shared update datapath sweeps all neurons per step,
// with a 4-entry spike FIFO. Define LIF_REFRACTORY_EN to add a 2-step refractory period per neuron.
module lif_scheduler #(
   parameter int NUM_NEURONS = 4,
   parameter int ID_W        = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            step,
   input  logic [7:0]      thr,
   input  logic            cur_valid,
   output logic            cur_ready,
   input  logic [ID_W-1:0] cur_id,
   input  logic [7:0]      cur_data,
   output logic            spk_valid,
   input  logic            spk_ready,
   output logic [ID_W-1:0] spk_id,
   output logic            spk_ovf,
   output logic            busy,
   output logic            step_done,
   input  logic [ID_W-1:0] mon_id,
   output logic [7:0]      mon_state
);
   localparam int FIFO_DEPTH = 4;

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} fsm_t;

   fsm_t            fsm_q;
   logic [ID_W-1:0] idx_q;
   logic            busy_q, done_q, ready_q;

   logic [7:0] state_w [NUM_NEURONS];
   logic [7:0] acc_w   [NUM_NEURONS];

   logic       hs, sweep_act;
   logic [8:0] acc_sum;
   logic [7:0] acc_sat;
   logic [7:0] cur_state, cur_acc;
   logic [8:0] sum;
   logic [7:0] sat, upd;
   logic       fire, hold, spike;

   assign hs        = cur_valid & ready_q;
   assign sweep_act = (fsm_q == SWEEP);

   // Saturating accumulate for the incoming current request
   assign acc_sum = {1'b0, acc_w[cur_id]} + {1'b0, cur_data};
   assign acc_sat = acc_sum[8] ? 8'hFF : acc_sum[7:0];

   // Shared leak/integrate/fire datapath for the neuron currently swept
   assign cur_state = state_w[idx_q];
   assign cur_acc   = acc_w[idx_q];
   assign sum       = {2'b00, cur_state[7:1]} + {1'b0, cur_acc};
   assign sat       = sum[8] ? 8'hFF : sum[7:0];
   assign fire      = (sat >= thr);
   assign upd       = sat - thr;

`ifdef LIF_REFRACTORY_EN
   logic [1:0] refr_w [NUM_NEURONS];
   assign hold = (refr_w[idx_q] != 2'd0);
`else
   assign hold = 1'b0;
`endif

   assign spike = sweep_act & fire & ~hold;

   generate
      for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
         logic [7:0] mem_q, mem_d;
         logic [7:0] ac_q, ac_d;
         logic       sel;

         assign sel         = sweep_act && (idx_q == ID_W'(gi));
         assign state_w[gi] = mem_q;
         assign acc_w[gi]   = ac_q;

         always_comb begin
            mem_d = mem_q;
            ac_d  = ac_q;
            if (sel) begin
               ac_d = 8'd0;
               if (!hold) mem_d = fire ? upd : sat;
            end else if (hs && (cur_id == ID_W'(gi))) begin
               ac_d = acc_sat;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               mem_q <= 8'd0;
               ac_q  <= 8'd0;
            end else begin
               mem_q <= mem_d;
               ac_q  <= ac_d;
            end
         end

`ifdef LIF_REFRACTORY_EN
         logic [1:0] rf_q, rf_d;
         assign refr_w[gi] = rf_q;

         always_comb begin
            rf_d = rf_q;
            if (sel) begin
               if (rf_q != 2'd0) rf_d = rf_q - 2'd1;
               else if (fire)    rf_d = 2'd2;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) rf_q <= 2'd0;
            else     rf_q <= rf_d;
         end
`endif
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (step) begin
                  fsm_q   <= SWEEP;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
               end
            end
            SWEEP: begin
               if (idx_q == ID_W'(NUM_NEURONS - 1)) begin
                  fsm_q  <= DONE;
                  idx_q  <= '0;
                  done_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               fsm_q   <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               fsm_q   <= IDLE;
               idx_q   <= '0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Spike FIFO: a push into a full FIFO still lands if the head pops in the same cycle
   logic [ID_W-1:0] fifo_q [FIFO_DEPTH];
   logic [1:0]      wr_q, rd_q;
   logic [2:0]      cnt_q;
   logic            ovf_q;
   logic            pop, push, full;

   assign full = (cnt_q == 3'(FIFO_DEPTH));
   assign pop  = (cnt_q != 3'd0) & spk_ready;
   assign push = spike & (~full | pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= 2'd0;
         rd_q  <= 2'd0;
         cnt_q <= 3'd0;
         ovf_q <= 1'b0;
         for (int k = 0; k < FIFO_DEPTH; k++) fifo_q[k] <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_q] <= idx_q;
            wr_q         <= wr_q + 2'd1;
         end
         if (pop) rd_q <= rd_q + 2'd1;
         cnt_q <= cnt_q + {2'b00, push} - {2'b00, pop};
         if (spike && full && !pop) ovf_q <= 1'b1;
      end
   end

   assign cur_ready = ready_q;
   assign busy      = busy_q;
   assign step_done = done_q;
   assign spk_valid = (cnt_q != 3'd0);
   assign spk_id    = fifo_q[rd_q];
   assign spk_ovf   = ovf_q;
   assign mon_state = state_w[mon_id];

endmodule
